// File: rtl/region_decoder.sv
// region_decoder: registered, runtime-programmable chip-select decoder for the
// 6809 bus. Windows match on the top address byte, each region can stretch the
// cycle with wait states, and flash regions can be gated by the FT2232 select.
module region_decoder #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned NUM_REGIONS = 8,
    parameter int unsigned WS_W        = 4,
    parameter int unsigned CFG_BASE    = 32'hA010
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_bus_req,
    input  logic                   i_rw,
    input  logic [ADDR_W-1:0]      i_address,
    input  logic [7:0]             i_wdata,
    input  logic                   i_FT_CS,
    output logic [NUM_REGIONS-1:0] o_ce,
    output logic                   o_cfg_ce,
    output logic [7:0]             o_rdata,
    output logic                   o_ready,
    output logic                   o_miss
);

    localparam int unsigned REG_W = $clog2(NUM_REGIONS);
    localparam int unsigned IDX_W = $clog2(NUM_REGIONS + 1);
    localparam logic [ADDR_W-1:0] CFG_LO = ADDR_W'(CFG_BASE);
    localparam logic [ADDR_W-1:0] CFG_HI = ADDR_W'(CFG_BASE + 4 * NUM_REGIONS);
    localparam logic [7:0] CTRL_MASK = 8'hC0 | 8'((1 << WS_W) - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_READY
    } state_t;

    // Per-region configuration and sticky status
    logic [7:0]      r_base [NUM_REGIONS];
    logic [7:0]      r_mask [NUM_REGIONS];
    logic [7:0]      r_ctrl [NUM_REGIONS];
    logic [1:0]      r_status;

    // Bus-cycle FSM state
    state_t          r_state;
    logic [WS_W-1:0] r_cnt;
    logic            r_gated;

    logic [7:0]       w_addr_hi;
    logic             w_cfg_hit;
    logic [ADDR_W-1:0] w_off;
    logic [IDX_W-1:0] w_idx;
    logic [1:0]       w_sub;
    logic             w_hit;
    logic [REG_W-1:0] w_win;
    logic [WS_W-1:0]  w_win_ws;
    logic             w_win_gate;
    logic [7:0]       w_rd;
    logic             w_start;
    logic             w_commit;
    logic             w_set_miss;
    logic             w_set_conf;
    logic [1:0]       w_clr;

    assign w_addr_hi = i_address[ADDR_W-1 -: 8];
    assign w_cfg_hit = (i_address >= CFG_LO) && (i_address <= CFG_HI);
    assign w_off     = i_address - CFG_LO;
    assign w_idx     = IDX_W'(w_off >> 2);
    assign w_sub     = w_off[1:0];

    // Resolve the winning region; scanning downward leaves the lowest index
    always_comb begin
        w_hit = 1'b0;
        w_win = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (r_ctrl[i][7] && ((w_addr_hi & r_mask[i]) == (r_base[i] & r_mask[i]))) begin
                w_hit = 1'b1;
                w_win = REG_W'(i);
            end
        end
    end

    assign w_win_ws   = r_ctrl[w_win][WS_W-1:0];
    assign w_win_gate = r_ctrl[w_win][6];

    // Config/status read mux for the addressed byte
    always_comb begin
        w_rd = 8'h00;
        if (w_idx == IDX_W'(NUM_REGIONS)) begin
            w_rd = {6'b0, r_status};
        end else begin
            case (w_sub)
                2'd0:    w_rd = r_base[REG_W'(w_idx)];
                2'd1:    w_rd = r_mask[REG_W'(w_idx)];
                2'd2:    w_rd = r_ctrl[REG_W'(w_idx)];
                default: w_rd = 8'h00;
            endcase
        end
    end

    assign w_start    = (r_state == ST_IDLE) && i_bus_req;
    assign w_commit   = w_start && w_cfg_hit && !i_rw;
    assign w_set_miss = w_start && !w_cfg_hit && !w_hit;
    assign w_set_conf = !i_FT_CS &&
                        ((w_start && !w_cfg_hit && w_hit && w_win_gate) ||
                         ((r_state != ST_IDLE) && r_gated));
    assign w_clr      = (w_commit && (w_idx == IDX_W'(NUM_REGIONS))) ? i_wdata[1:0] : 2'b00;

    // Configuration registers and sticky status; a set beats a clear
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int n = 0; n < NUM_REGIONS; n++) begin
                r_base[n] <= 8'h00;
                r_mask[n] <= 8'h00;
                r_ctrl[n] <= 8'h00;
            end
            r_base[0] <= 8'h10;
            r_mask[0] <= 8'hF0;
            r_ctrl[0] <= 8'h80;
            r_base[1] <= 8'h30;
            r_mask[1] <= 8'hF0;
            r_ctrl[1] <= 8'hC2;
            r_status  <= 2'b00;
        end else begin
            if (w_commit && (w_idx < IDX_W'(NUM_REGIONS))) begin
                case (w_sub)
                    2'd0:    r_base[REG_W'(w_idx)] <= i_wdata;
                    2'd1:    r_mask[REG_W'(w_idx)] <= i_wdata;
                    2'd2:    r_ctrl[REG_W'(w_idx)] <= i_wdata & CTRL_MASK;
                    default: ;
                endcase
            end
            r_status <= (r_status & ~w_clr) | {w_set_conf, w_set_miss};
        end
    end

    // Bus-cycle FSM: latch the decision at cycle start, stretch, then hold ready
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_gated  <= 1'b0;
            o_ce     <= '0;
            o_cfg_ce <= 1'b0;
            o_rdata  <= 8'h00;
            o_ready  <= 1'b0;
            o_miss   <= 1'b0;
        end else begin
            o_miss <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_bus_req) begin
                        if (w_cfg_hit) begin
                            o_cfg_ce <= 1'b1;
                            o_rdata  <= i_rw ? w_rd : 8'h00;
                            r_gated  <= 1'b0;
                            r_cnt    <= '0;
                            o_ready  <= 1'b1;
                            r_state  <= ST_READY;
                        end else if (w_hit) begin
                            o_ce     <= (w_win_gate && !i_FT_CS) ? '0 : NUM_REGIONS'(1) << w_win;
                            o_rdata  <= 8'h00;
                            r_gated  <= w_win_gate;
                            r_cnt    <= w_win_ws;
                            if (w_win_ws == '0) begin
                                o_ready <= 1'b1;
                                r_state <= ST_READY;
                            end else begin
                                r_state <= ST_WAIT;
                            end
                        end else begin
                            o_miss   <= 1'b1;
                            o_rdata  <= 8'h00;
                            r_gated  <= 1'b0;
                            r_cnt    <= '0;
                            o_ready  <= 1'b1;
                            r_state  <= ST_READY;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!i_bus_req) begin
                        o_ce    <= '0;
                        o_ready <= 1'b0;
                        r_gated <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        if (r_cnt <= WS_W'(1)) begin
                            o_ready <= 1'b1;
                            r_state <= ST_READY;
                        end else begin
                            r_cnt <= r_cnt - WS_W'(1);
                        end
                        if (r_gated && !i_FT_CS) begin
                            o_ce <= '0;
                        end
                    end
                end
                ST_READY: begin
                    if (!i_bus_req) begin
                        o_ce     <= '0;
                        o_cfg_ce <= 1'b0;
                        o_ready  <= 1'b0;
                        o_rdata  <= 8'h00;
                        r_gated  <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else if (r_gated && !i_FT_CS) begin
                        o_ce <= '0;
                    end
                end
                default: begin
                    o_ce     <= '0;
                    o_cfg_ce <= 1'b0;
                    o_ready  <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
